imem_dp_bram: RTL and testbench

IMEM_DP_BRAM -- requirements
Module: imem_dp_bram

---
 rtl/imem_dp_bram.sv | 237 +++++++++++++++++++++++
 tb/tb_imem_dp_bram.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dp_bram.sv
// ============================================================================
// Module   : imem_dp_bram
// Brief    : Dual-port instruction memory: pipelined in-order fetch port with
//            response buffer and flush, plus a byte-writable load/debug port B.
//            Optional per-byte even parity when IMEM_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_dp_bram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 256,
    parameter int OUT_REG    = 0,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    input  logic                    b_en,
    input  logic                    b_we,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid
`ifdef IMEM_PARITY_EN
    ,
    output logic                    rsp_perr,
    output logic                    b_perr
`endif
);

    localparam int c_nb = DATA_WIDTH / 8;
`ifdef IMEM_PARITY_EN
    localparam int c_pw = DATA_WIDTH + c_nb;
`else
    localparam int c_pw = DATA_WIDTH;
`endif
    localparam int c_cw  = $clog2(RSP_DEPTH + 1);
    localparam int c_fpw = $clog2(RSP_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_mem_lim   = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [c_cw-1:0]     c_depth     = c_cw'(RSP_DEPTH);
    localparam logic [c_fpw-1:0]    c_fifo_last = c_fpw'(RSP_DEPTH - 1);

`ifdef IMEM_PARITY_EN
    function automatic logic [c_nb-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        logic [c_nb-1:0] p;
        p = '0;
        for (int i = 0; i < c_nb; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction
`endif

    // Stored word: data in the low bits, parity bits (if any) above.
    logic [c_pw-1:0] r_mem [MEM_SIZE];

    logic w_b_in_range;
    logic w_f_in_range;
    logic w_b_wr;
    logic w_b_rd;
    logic w_accept;
    logic w_pop_fire;

    assign w_b_in_range = ({1'b0, b_addr} < c_mem_lim);
    assign w_f_in_range = ({1'b0, req_addr} < c_mem_lim);
    assign w_b_wr       = enable && b_en && b_we && w_b_in_range;
    assign w_b_rd       = enable && b_en && !b_we;

    always_ff @(posedge clk) begin : p_mem_wr
        if (w_b_wr) begin
            for (int i = 0; i < c_nb; i++) begin
                if (b_be[i]) begin
                    r_mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
`ifdef IMEM_PARITY_EN
                    r_mem[b_addr][DATA_WIDTH+i] <= ^b_wdata[8*i +: 8];
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch pipeline and outstanding accounting
    // ------------------------------------------------------------------
    logic              r_live;
    logic              r_s1_valid;
    logic [c_pw-1:0]   r_s1_data;
    logic [c_cw-1:0]   r_out;
    logic              w_last_valid;
    logic [c_pw-1:0]   w_last_data;

    assign w_accept  = req_valid && req_ready;
    // r_live keeps req_ready low while reset is held, even with enable high.
    assign req_ready = r_live && enable && !flush && ((r_out < c_depth) || w_pop_fire);

    always_ff @(posedge clk or negedge rst_n) begin : p_fetch
        if (!rst_n) begin
            r_live     <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_out      <= '0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_out      <= '0;
            end else begin
                r_s1_valid <= w_accept;
                case ({w_accept, w_pop_fire})
                    2'b10:   r_out <= r_out + c_cw'(1);
                    2'b01:   r_out <= r_out - c_cw'(1);
                    default: r_out <= r_out;
                endcase
            end
            if (w_accept) begin
                r_s1_data <= w_f_in_range ? r_mem[req_addr] : '0;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic            r_s2_valid;
            logic [c_pw-1:0] r_s2_data;

            always_ff @(posedge clk or negedge rst_n) begin : p_s2
                if (!rst_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid && !flush;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign w_last_valid = r_s2_valid;
            assign w_last_data  = r_s2_data;
        end else begin : g_no_out_reg
            assign w_last_valid = r_s1_valid;
            assign w_last_data  = r_s1_data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response buffer; the pipeline output bypasses it when it is empty.
    // Capacity RSP_DEPTH cannot overflow since outstanding is capped there.
    // ------------------------------------------------------------------
    logic [c_pw-1:0]  r_fifo [RSP_DEPTH];
    logic [c_fpw-1:0] r_wptr;
    logic [c_fpw-1:0] r_rptr;
    logic [c_cw-1:0]  r_fcnt;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic [c_pw-1:0]  w_rsp_word;

    assign w_fifo_empty = (r_fcnt == '0);
    assign w_push       = w_last_valid && !(w_fifo_empty && rsp_ready);
    assign w_pop        = !w_fifo_empty && rsp_ready;
    assign rsp_valid    = !w_fifo_empty || w_last_valid;
    assign w_pop_fire   = rsp_valid && rsp_ready;
    assign w_rsp_word   = w_fifo_empty ? w_last_data : r_fifo[r_rptr];
    assign rsp_data     = w_rsp_word[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin : p_fifo_mem
        if (w_push && !flush) begin
            r_fifo[r_wptr] <= w_last_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_fifo_ctl
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_fifo_last) ? '0 : r_wptr + c_fpw'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_fifo_last) ? '0 : r_rptr + c_fpw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + c_cw'(1);
                2'b01:   r_fcnt <= r_fcnt - c_cw'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Port B read path: fixed one-cycle latency
    // ------------------------------------------------------------------
    logic            r_b_rvalid;
    logic [c_pw-1:0] r_b_word;

    always_ff @(posedge clk or negedge rst_n) begin : p_port_b
        if (!rst_n) begin
            r_b_rvalid <= 1'b0;
            r_b_word   <= '0;
        end else begin
            r_b_rvalid <= w_b_rd;
            if (w_b_rd) begin
                r_b_word <= w_b_in_range ? r_mem[b_addr] : '0;
            end
        end
    end

    assign b_rvalid = r_b_rvalid;
    assign b_rdata  = r_b_word[DATA_WIDTH-1:0];

`ifdef IMEM_PARITY_EN
    assign rsp_perr = rsp_valid &&
                      (byte_parity(w_rsp_word[DATA_WIDTH-1:0]) != w_rsp_word[c_pw-1:DATA_WIDTH]);
    assign b_perr   = r_b_rvalid &&
                      (byte_parity(r_b_word[DATA_WIDTH-1:0]) != r_b_word[c_pw-1:DATA_WIDTH]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_dp_bram.sv
// ============================================================================
// Module   : tb_imem_dp_bram
// Brief    : Directed self-checking bench for imem_dp_bram (OUT_REG=0,
//            MEM_SIZE=200 so out-of-range addresses are reachable).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_dp_bram;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MS = 200;

    logic          clk = 1'b0;
    logic          rst_n, enable, flush;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          b_en, b_we;
    logic [3:0]    b_be;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          b_rvalid;

    always #5 clk = ~clk;

    imem_dp_bram #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .OUT_REG(0), .RSP_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rdata(b_rdata), .b_rvalid(b_rvalid)
    );

    int          errors = 0;
    int          checks = 0;
    int          rsp_seen = 0;
    logic [31:0] model [256];
    logic [31:0] expq [$];

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] a);
        return (a < MS) ? model[a] : 32'h0;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        if (a < MS) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic bwrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        b_en = 1'b1; b_we = 1'b1; b_addr = a; b_wdata = d; b_be = be;
        step;
        b_en = 1'b0; b_we = 1'b0;
        model_write(a, d, be);
    endtask

    // Present a fetch and hold it until accepted; returns 1ns after the accept edge.
    task automatic fetch(input logic [7:0] a);
        int n;
        n = 0;
        req_addr = a; req_valid = 1'b1;
        #1;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout addr=%0d: req_ready got 0 expected 1", a);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Scoreboard: every handshaken response must match the oldest accepted fetch.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            expq.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                if (expq.size() == 0) chk("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
                else                  chk("rsp_order", rsp_data, expq.pop_front());
            end
            if (req_valid && req_ready) expq.push_back(exp_word(req_addr));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;

        rst_n = 1'b0; enable = 1'b1; flush = 1'b0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        b_en = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < 256; i++) model[i] = 32'h0;

        #2;
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_data",  rsp_data, 32'h0);
        chk("rst_b_rvalid",  {31'h0, b_rvalid}, 32'h0);
        chk("rst_b_rdata",   b_rdata, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        step; step;
        rst_n = 1'b1;
        step;

        for (int i = 0; i < 32; i++) bwrite(8'(i), 32'hC0DE0000 | 32'(i), 4'hF);

        vt[0]  = '{1'b1, 4'hF,    8'd5,   32'hDEADBEEF, 32'h0};
        vt[1]  = '{1'b0, 4'h0,    8'd5,   32'h0,        32'hDEADBEEF};
        vt[2]  = '{1'b1, 4'b0010, 8'd5,   32'h00001200, 32'h0};
        vt[3]  = '{1'b0, 4'h0,    8'd5,   32'h0,        32'hDEAD12EF};
        vt[4]  = '{1'b1, 4'hF,    8'd199, 32'h12345678, 32'h0};
        vt[5]  = '{1'b1, 4'b1000, 8'd199, 32'hAB000000, 32'h0};
        vt[6]  = '{1'b1, 4'b0000, 8'd199, 32'hFFFFFFFF, 32'h0};
        vt[7]  = '{1'b0, 4'h0,    8'd199, 32'h0,        32'hAB345678};
        vt[8]  = '{1'b1, 4'hF,    8'd250, 32'hFFFFFFFF, 32'h0};
        vt[9]  = '{1'b0, 4'h0,    8'd250, 32'h0,        32'h0};
        vt[10] = '{1'b0, 4'h0,    8'd0,   32'h0,        32'hC0DE0000};

        for (int k = 0; k < 11; k++) begin
            b_en = 1'b1; b_we = vt[k].we; b_be = vt[k].be;
            b_addr = vt[k].addr; b_wdata = vt[k].wdata;
            step;
            b_en = 1'b0; b_we = 1'b0;
            if (vt[k].we) begin
                model_write(vt[k].addr, vt[k].wdata, vt[k].be);
                chk($sformatf("vec%0d_wr_rvalid", k), {31'h0, b_rvalid}, 32'h0);
            end else begin
                chk($sformatf("vec%0d_rvalid", k), {31'h0, b_rvalid}, 32'h1);
                chk($sformatf("vec%0d_rdata", k), b_rdata, vt[k].exp);
            end
            step;
            chk($sformatf("vec%0d_idle_rvalid", k), {31'h0, b_rvalid}, 32'h0);
            if (!vt[k].we) chk($sformatf("vec%0d_rdata_hold", k), b_rdata, vt[k].exp);
        end

        // Single fetch latency
        chk("lat_pre_valid", {31'h0, rsp_valid}, 32'h0);
        fetch(8'd5);
        chk("lat_valid", {31'h0, rsp_valid}, 32'h1);
        chk("lat_data", rsp_data, 32'hDEAD12EF);
        step;

        // Back-to-back with backpressure after two responses
        base = rsp_seen;
        fetch(8'd0); fetch(8'd1); fetch(8'd2);
        rsp_ready = 1'b0;
        fetch(8'd3); fetch(8'd4); fetch(8'd5);
        req_addr = 8'd6; req_valid = 1'b1;
        #1;
        chk("bp_req_ready_full", {31'h0, req_ready}, 32'h0);
        chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("bp_rsp_data", rsp_data, model[2]);
        step; step; step;
        chk("bp_rsp_data_stable", rsp_data, model[2]);
        chk("bp_still_full", {31'h0, req_ready}, 32'h0);
        rsp_ready = 1'b1;
        fetch(8'd6); fetch(8'd7);
        repeat (8) step;
        chk("bp_rsp_count", 32'(rsp_seen - base), 32'd8);
        chk("bp_queue_empty", 32'(expq.size()), 32'd0);

        // Flush with four outstanding
        rsp_ready = 1'b0;
        fetch(8'd10); fetch(8'd11); fetch(8'd12); fetch(8'd13);
        req_addr = 8'd9; req_valid = 1'b1; flush = 1'b1;
        #1;
        chk("flush_req_ready", {31'h0, req_ready}, 32'h0);
        chk("flush_pre_valid", {31'h0, rsp_valid}, 32'h1);
        step;
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        chk("flush_rsp_cleared", {31'h0, rsp_valid}, 32'h0);
        fetch(8'd9);
        chk("flush_next_valid", {31'h0, rsp_valid}, 32'h1);
        chk("flush_next_data", rsp_data, model[9]);
        step;
        chk("flush_no_stale", {31'h0, rsp_valid}, 32'h0);

        // Read-first collision
        bwrite(8'd3, 32'h11111111, 4'hF);
        req_addr = 8'd3; req_valid = 1'b1;
        b_en = 1'b1; b_we = 1'b1; b_addr = 8'd3; b_wdata = 32'h22222222; b_be = 4'hF;
        step;
        req_valid = 1'b0; b_en = 1'b0; b_we = 1'b0;
        model_write(8'd3, 32'h22222222, 4'hF);
        chk("coll_old_data", rsp_data, 32'h11111111);
        fetch(8'd3);
        chk("coll_new_data", rsp_data, 32'h22222222);
        step;

        // enable=0 blocks fetch accepts and port B
        enable = 1'b0;
        b_en = 1'b1; b_we = 1'b0; b_addr = 8'd5;
        req_addr = 8'd5; req_valid = 1'b1;
        #1;
        chk("dis_req_ready", {31'h0, req_ready}, 32'h0);
        step;
        chk("dis_b_rvalid", {31'h0, b_rvalid}, 32'h0);
        b_we = 1'b1; b_addr = 8'd6; b_wdata = 32'h0BAD0BAD; b_be = 4'hF;
        step;
        b_we = 1'b0; req_valid = 1'b0; enable = 1'b1;
        step;
        b_en = 1'b0;
        chk("dis_write_ignored", b_rdata, 32'hC0DE0006);
        rsp_ready = 1'b0;
        fetch(8'd7);
        enable = 1'b0; rsp_ready = 1'b1;
        chk("dis_drain_valid", {31'h0, rsp_valid}, 32'h1);
        chk("dis_drain_data", rsp_data, model[7]);
        step;
        chk("dis_drain_done", {31'h0, rsp_valid}, 32'h0);
        enable = 1'b1;

        // Reset with fetches outstanding
        rsp_ready = 1'b0;
        fetch(8'd20); fetch(8'd21); fetch(8'd22);
        b_en = 1'b1; b_we = 1'b0; b_addr = 8'd1;
        step;
        b_en = 1'b0;
        chk("prerst_b_rvalid", {31'h0, b_rvalid}, 32'h1);
        chk("prerst_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("midrst_b_rvalid", {31'h0, b_rvalid}, 32'h0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("midrst_rsp_data", rsp_data, 32'h0);
        step; step;
        rst_n = 1'b1; rsp_ready = 1'b1;
        cnt = 0;
        repeat (6) begin
            step;
            if (rsp_valid) cnt++;
        end
        chk("postrst_no_stale", 32'(cnt), 32'd0);
        fetch(8'd9);
        chk("postrst_mem_kept", rsp_data, model[9]);
        repeat (3) step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
